// File: rtl/run_checker.sv
// Run checker: arms on start, watches the CPU fetch PC for a halt, then sweeps and compares the register file.
// Latency: halt declared HALT_STABLE-1 unstalled equal-PC cycles after the last PC change; sweep adds NREG*(READ_LAT+1) cycles.
// Backpressure: none; stall only freezes the halt-stability count, and start is honoured only in IDLE or DONE.
module run_checker #(
    parameter int XLEN        = 32,
    parameter int NREG        = 32,
    parameter int SEL_W       = 5,
    parameter int HALT_STABLE = 8,
    parameter int TIMEOUT     = 10000,
    parameter int READ_LAT    = 1,
    parameter int ERR_W       = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [XLEN-1:0]   pc,
    input  logic              stall,
    output logic [SEL_W-1:0]  reg_sel,
    input  logic [XLEN-1:0]   reg_data,
    input  logic [XLEN-1:0]   exp_data,
    input  logic              exp_care,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [SEL_W-1:0]  first_err,
    output logic [31:0]       cycle_cnt
);

    // Counter widths and terminal values, sized to the counters they are compared against.
    localparam int STAB_W = $clog2(HALT_STABLE) + 1;
    localparam int LAT_W  = 2;

    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(HALT_STABLE - 1);
    localparam logic [31:0]       TMO_LAST  = 32'(TIMEOUT - 1);
    localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NREG - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'((READ_LAT > 0) ? (READ_LAT - 1) : 0);
    localparam bit                SKIP_SETTLE = (READ_LAT == 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // State and datapath registers.
    state_t             r_state;
    logic [XLEN-1:0]    r_pc_q;
    logic [STAB_W-1:0]  r_stab;
    logic [LAT_W-1:0]   r_lat;
    logic [SEL_W-1:0]   r_reg_sel;
    logic               r_done;
    logic               r_pass;
    logic               r_timeout;
    logic [ERR_W-1:0]   r_err_cnt;
    logic [SEL_W-1:0]   r_first_err;
    logic [31:0]        r_cycle_cnt;

    // Next-state values and helper terms.
    state_t             w_state_nxt;
    logic [STAB_W-1:0]  w_stab_nxt;
    logic [LAT_W-1:0]   w_lat_nxt;
    logic [SEL_W-1:0]   w_reg_sel_nxt;
    logic               w_done_nxt;
    logic               w_pass_nxt;
    logic               w_timeout_nxt;
    logic [ERR_W-1:0]   w_err_cnt_nxt;
    logic [SEL_W-1:0]   w_first_err_nxt;
    logic [31:0]        w_cycle_cnt_nxt;

    logic [STAB_W-1:0]  w_stab_upd;
    logic               w_halt;
    logic               w_tmo;
    logic [31:0]        w_cyc_inc;
    logic               w_mismatch;
    logic [ERR_W-1:0]   w_err_inc;
    logic               w_last;

    // Every output comes straight from a register.
    assign reg_sel   = r_reg_sel;
    assign done      = r_done;
    assign pass      = r_pass;
    assign timeout   = r_timeout;
    assign err_cnt   = r_err_cnt;
    assign first_err = r_first_err;
    assign cycle_cnt = r_cycle_cnt;

    // Halt detector, saturating counters and compare term shared by the FSM.
    always_comb begin
        w_stab_upd = r_stab;
        if (pc != r_pc_q) begin
            w_stab_upd = '0;
        end else if (!stall) begin
            w_stab_upd = r_stab + 1'b1;
        end
        w_halt     = (w_stab_upd == STAB_LAST);
        w_tmo      = (r_cycle_cnt == TMO_LAST);
        w_cyc_inc  = (r_cycle_cnt == 32'hFFFF_FFFF) ? r_cycle_cnt : (r_cycle_cnt + 32'd1);
        w_mismatch = exp_care && (reg_data != exp_data);
        w_err_inc  = (&r_err_cnt) ? r_err_cnt : (r_err_cnt + 1'b1);
        w_last     = (r_reg_sel == SEL_LAST);
    end

    // FSM next-state and register next values; everything holds unless a state says otherwise.
    always_comb begin
        w_state_nxt     = r_state;
        w_stab_nxt      = r_stab;
        w_lat_nxt       = r_lat;
        w_reg_sel_nxt   = r_reg_sel;
        w_done_nxt      = r_done;
        w_pass_nxt      = r_pass;
        w_timeout_nxt   = r_timeout;
        w_err_cnt_nxt   = r_err_cnt;
        w_first_err_nxt = r_first_err;
        w_cycle_cnt_nxt = r_cycle_cnt;

        case (r_state)
            S_IDLE, S_DONE: begin
                // A restart from DONE is identical to a start from IDLE.
                if (start) begin
                    w_state_nxt     = S_RUN;
                    w_stab_nxt      = '0;
                    w_lat_nxt       = '0;
                    w_reg_sel_nxt   = '0;
                    w_done_nxt      = 1'b0;
                    w_pass_nxt      = 1'b0;
                    w_timeout_nxt   = 1'b0;
                    w_err_cnt_nxt   = '0;
                    w_first_err_nxt = '0;
                    w_cycle_cnt_nxt = '0;
                end
            end

            S_RUN: begin
                w_cycle_cnt_nxt = w_cyc_inc;
                w_stab_nxt      = w_stab_upd;
                // Halt takes priority over a timeout landing on the same cycle.
                if (w_halt) begin
                    w_reg_sel_nxt = '0;
                    w_lat_nxt     = '0;
                    w_state_nxt   = SKIP_SETTLE ? S_CHECK : S_SETTLE;
                end else if (w_tmo) begin
                    w_state_nxt   = S_DONE;
                    w_done_nxt    = 1'b1;
                    w_timeout_nxt = 1'b1;
                    w_pass_nxt    = 1'b0;
                end
            end

            S_SETTLE: begin
                // Hold reg_sel for READ_LAT cycles so reg_data reflects it in CHECK.
                if (r_lat == LAT_LAST) begin
                    w_lat_nxt   = '0;
                    w_state_nxt = S_CHECK;
                end else begin
                    w_lat_nxt = r_lat + 1'b1;
                end
            end

            S_CHECK: begin
                if (w_mismatch) begin
                    w_err_cnt_nxt = w_err_inc;
                    if (r_err_cnt == '0) begin
                        w_first_err_nxt = r_reg_sel;
                    end
                end
                if (w_last) begin
                    w_state_nxt   = S_DONE;
                    w_done_nxt    = 1'b1;
                    w_timeout_nxt = 1'b0;
                    w_pass_nxt    = !w_mismatch && (r_err_cnt == '0);
                end else begin
                    w_reg_sel_nxt = r_reg_sel + 1'b1;
                    w_lat_nxt     = '0;
                    w_state_nxt   = SKIP_SETTLE ? S_CHECK : S_SETTLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register; reset returns to IDLE from anywhere, including mid-sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers; the PC sample runs every cycle so the first RUN compare sees the PC at start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_q      <= '0;
            r_stab      <= '0;
            r_lat       <= '0;
            r_reg_sel   <= '0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
            r_cycle_cnt <= '0;
        end else begin
            r_pc_q      <= pc;
            r_stab      <= w_stab_nxt;
            r_lat       <= w_lat_nxt;
            r_reg_sel   <= w_reg_sel_nxt;
            r_done      <= w_done_nxt;
            r_pass      <= w_pass_nxt;
            r_timeout   <= w_timeout_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
            r_first_err <= w_first_err_nxt;
            r_cycle_cnt <= w_cycle_cnt_nxt;
        end
    end

endmodule
